alu_pc_seq: RTL and testbench
=============================

Name: alu_pc_seq

Overview:
- Clocked, parametrised successor of the 2-bit ALU/PC block; drives the microprocessor program counter.
- Executes one instruction per enabled cycle: pass, add, subtract, conditional and unconditional relative jumps, halt.
- Result, PC and flags are registered, so there are no combinational PC update loops.
- Sits between instruction decode (supplies `sel`, `a`, `b`) and the instruction fetch address.

Parameters:
- DATA_W, 8, width of operands `a`, `b` and result `out`
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  step strobe; instruction in `sel`/`a`/`b` is executed on a rising clk edge when `en`=1
- sel  input  3  opcode
- a  input  DATA_W  operand / jump offset (unsigned magnitude)
- b  input  DATA_W  operand / branch condition register
- out  output  DATA_W  registered ALU result
- pc  output  PC_W  registered program counter
- zero  output  1  registered: last arithmetic result == 0
- carry  output  1  registered: add carry-out / subtract borrow
- halted  output  1  high while in HALT state

Behaviour:
- Reset (synchronous, `rst`=1 at the clk edge):
  - `out`=0, `pc`=RESET_PC, `zero`=0, `carry`=0, `halted`=0, state=RUN.
  - `rst` overrides `en`.
- Latency: all outputs update on the clk edge that samples `en`=1; visible one cycle after issue.
- States: RUN, HALT.
  - RUN→HALT on `en`=1 with `sel`=111.
  - HALT→RUN only via `rst`.
  - In HALT, `en` is ignored and all outputs hold.
- `en`=0 in RUN: all registers hold.
- Opcodes (RUN, `en`=1):
  - 000 pass: `out`=`a`; `pc`+=1.
  - 001 add: `out`=`b`+`a` (low DATA_W bits); `carry`=bit DATA_W of the sum; `pc`+=1.
  - 010 sub: `out`=`b`-`a`; `carry`=1 if `a`>`b` (borrow); `pc`+=1.
  - 011 cond jump down: `pc`+=`a` if `b`==0, else `pc`+=1.
  - 100 cond jump up: `pc`-=`a` if `b`==0, else `pc`+=1.
  - 101 uncond jump down: `pc`+=`a`.
  - 110 uncond jump up: `pc`-=`a`.
  - 111 halt: `pc` holds; `halted`=1 from the next cycle.
- Offset arithmetic:
  - `a` is zero-extended or truncated to PC_W.
  - Add/subtract is modulo 2^PC_W; wrap-around in both directions is legal and silent.
  - `a`=0 on a taken jump holds `pc` (self-loop).
- `zero` is updated only on 000/001/010 and equals (new `out`==0). `carry` is updated only on 001/010. Both hold on all other opcodes.
- `out` holds on jump and halt opcodes.
- The condition `b`==0 compares all DATA_W bits; X/Z on `b` must not occur (verification asserts known values when `en`=1).

Optional Feature:
- Macro ALU_PC_SAT_EN.
- Defined:
  - 001 saturates `out` at 2^DATA_W-1; 010 saturates at 0.
  - `carry` still reports the raw overflow/borrow.
  - `zero` reflects the saturated value.
- Undefined: plain modulo wrap as described above.
- PC arithmetic never saturates in either case.

Decomposition:
- Package alu_pc_pkg holds:
  - opcode localparams OP_PASS, OP_ADD, OP_SUB, OP_CJD, OP_CJU, OP_JD, OP_JU, OP_HALT (3-bit);
  - the state encoding ST_RUN/ST_HALT.
- One combinational sub-module, pc_next_calc: inputs `pc`, `sel`, `a`, `b`; output next PC. It isolates branch/offset logic for separate unit testing.
- ALU datapath and state register stay in the top module.

Test Plan:
- Reset then `en`=1, `sel`=001, `a`=8'h05, `b`=8'h03 → `out`=8'h08, `pc`=1, `zero`=0, `carry`=0.
- `sel`=001, `a`=8'hFF, `b`=8'h01 → `out`=8'h00, `zero`=1, `carry`=1 (with ALU_PC_SAT_EN: `out`=8'hFF, `zero`=0, `carry`=1).
- `pc`=8'h02, `sel`=110, `a`=8'h05 → `pc`=8'hFD (wrap). Then `sel`=101, `a`=8'h05 → `pc`=8'h02.
- `pc`=8'h10, `sel`=011, `b`=8'h00, `a`=8'h04 → `pc`=8'h14. Repeat with `b`=8'h01 → `pc`=8'h15.
- `sel`=111 → `halted`=1 next cycle. Further `en`=1 with `sel`=001 → `out`/`pc` unchanged. `rst`=1 → `pc`=RESET_PC, `halted`=0.
- `rst`=1 asserted together with `en`=1, `sel`=101 → the reset values win; `en`=0 for 5 cycles → all outputs stable.

Source files
------------

// File: rtl/alu_pc_pkg.sv
// Shared opcode values and RUN/HALT state encoding for the ALU/PC sequencer.
package alu_pc_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_CJD  = 3'b011;
  localparam logic [2:0] OP_CJU  = 3'b100;
  localparam logic [2:0] OP_JD   = 3'b101;
  localparam logic [2:0] OP_JU   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC calculation: increment, conditional/unconditional relative jumps, halt hold.
// Purely combinational; no backpressure, PC arithmetic wraps modulo 2^PC_W.
module pc_next_calc
  import alu_pc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic [PC_W-1:0]   pc,
  input  logic [2:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [PC_W-1:0]   pc_next
);

  logic [PC_W-1:0] w_off;
  logic [PC_W-1:0] w_inc;
  logic [PC_W-1:0] w_fwd;
  logic [PC_W-1:0] w_back;
  logic            w_b_zero;

  // Offset is an unsigned magnitude resized to the PC width.
  if (DATA_W >= PC_W) begin : g_trunc
    assign w_off = a[PC_W-1:0];
  end else begin : g_zext
    assign w_off = {{(PC_W-DATA_W){1'b0}}, a};
  end

  assign w_b_zero = (b == '0);
  assign w_inc    = pc + PC_W'(1);
  assign w_fwd    = pc + w_off;
  assign w_back   = pc - w_off;

  always_comb begin
    pc_next = w_inc;
    case (sel)
      OP_CJD:  pc_next = w_b_zero ? w_fwd : w_inc;
      OP_CJU:  pc_next = w_b_zero ? w_back : w_inc;
      OP_JD:   pc_next = w_fwd;
      OP_JU:   pc_next = w_back;
      OP_HALT: pc_next = pc;
      default: pc_next = w_inc;
    endcase
  end

endmodule

// File: rtl/alu_pc_seq.sv
// Registered ALU + program counter, one instruction per en cycle, results visible next cycle;
// en=0 or HALT holds everything. ALU_PC_SAT_EN selects saturating add/sub results.
module alu_pc_seq
  import alu_pc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [2:0]        sel,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] out,
  output logic [PC_W-1:0]   pc,
  output logic              zero,
  output logic              carry,
  output logic              halted
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_step;
  logic [DATA_W-1:0] r_out;
  logic [PC_W-1:0]   r_pc;
  logic              r_zero;
  logic              r_carry;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_add_res;
  logic [DATA_W-1:0] w_sub_res;

  pc_next_calc #(
    .DATA_W(DATA_W),
    .PC_W  (PC_W)
  ) u_pc_next (
    .pc     (r_pc),
    .sel    (sel),
    .a      (a),
    .b      (b),
    .pc_next(w_pc_nxt)
  );

  // Top bit of the extended sum is the carry; of the difference, the borrow (a > b).
  assign w_sum  = {1'b0, b} + {1'b0, a};
  assign w_diff = {1'b0, b} - {1'b0, a};

`ifdef ALU_PC_SAT_EN
  assign w_add_res = w_sum[DATA_W]  ? '1 : w_sum[DATA_W-1:0];
  assign w_sub_res = w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0];
`else
  assign w_add_res = w_sum[DATA_W-1:0];
  assign w_sub_res = w_diff[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_RUN && en && sel == OP_HALT) w_state_nxt = ST_HALT;
  end

  always_comb begin
    halted = (r_state == ST_HALT);
    w_step = (r_state == ST_RUN) && en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_pc    <= PC_W'(RESET_PC);
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (w_step) begin
      r_pc <= w_pc_nxt;
      case (sel)
        OP_PASS: begin
          r_out  <= a;
          r_zero <= (a == '0);
        end
        OP_ADD: begin
          r_out   <= w_add_res;
          r_zero  <= (w_add_res == '0);
          r_carry <= w_sum[DATA_W];
        end
        OP_SUB: begin
          r_out   <= w_sub_res;
          r_zero  <= (w_sub_res == '0);
          r_carry <= w_diff[DATA_W];
        end
        default: ;
      endcase
    end
  end

  assign out   = r_out;
  assign pc    = r_pc;
  assign zero  = r_zero;
  assign carry = r_carry;

endmodule

// File: tb/tb_alu_pc_seq.sv
// Directed-vector bench for alu_pc_seq with an integer-arithmetic reference model checked every cycle.
module tb_alu_pc_seq;

  localparam int DW  = 8;
  localparam int PW  = 8;
  localparam int DM  = 2 ** DW;
  localparam int PM  = 2 ** PW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [2:0]    sel = 3'd0;
  logic [DW-1:0] a   = '0;
  logic [DW-1:0] b   = '0;
  logic [DW-1:0] out;
  logic [PW-1:0] pc;
  logic          zero;
  logic          carry;
  logic          halted;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  int m_out, m_pc, m_zero, m_carry, m_halt;

  alu_pc_seq #(.DATA_W(DW), .PC_W(PW), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .a(a), .b(b),
    .out(out), .pc(pc), .zero(zero), .carry(carry), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour in plain integer arithmetic.
  task automatic model_step(input bit r, input bit e, input int s, input int av, input int bv);
    int t;
    if (r) begin
      m_out = 0; m_pc = 0; m_zero = 0; m_carry = 0; m_halt = 0;
    end else if (e && !m_halt) begin
      case (s)
        0: begin m_out = av; m_zero = (av == 0); m_pc = (m_pc + 1) % PM; end
        1: begin
          t = bv + av;
          m_carry = (t >= DM);
`ifdef ALU_PC_SAT_EN
          m_out = (t >= DM) ? DM - 1 : t;
`else
          m_out = t % DM;
`endif
          m_zero = (m_out == 0);
          m_pc = (m_pc + 1) % PM;
        end
        2: begin
          t = bv - av;
          m_carry = (av > bv);
`ifdef ALU_PC_SAT_EN
          m_out = (t < 0) ? 0 : t;
`else
          m_out = (t + DM) % DM;
`endif
          m_zero = (m_out == 0);
          m_pc = (m_pc + 1) % PM;
        end
        3: m_pc = (bv == 0) ? (m_pc + av) % PM : (m_pc + 1) % PM;
        4: m_pc = (bv == 0) ? ((m_pc - av) % PM + PM) % PM : (m_pc + 1) % PM;
        5: m_pc = (m_pc + av) % PM;
        6: m_pc = ((m_pc - av) % PM + PM) % PM;
        default: m_halt = 1;
      endcase
    end
  endtask

  task automatic apply(input bit r, input bit e, input int s, input int av, input int bv);
    rst = r; en = e; sel = 3'(s); a = DW'(av); b = DW'(bv);
    @(posedge clk);
    model_step(r, e, s, av, bv);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out",    int'(out),    m_out);
      check("pc",     int'(pc),     m_pc);
      check("zero",   int'(zero),   m_zero);
      check("carry",  int'(carry),  m_carry);
      check("halted", int'(halted), m_halt);
    end
  end

  initial begin
    apply(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    check("rst_pc", int'(pc), 0);
    check("rst_out", int'(out), 0);
    check("rst_halted", int'(halted), 0);

    apply(0, 1, 1, 'h05, 'h03);
    check("add1_out", int'(out), 'h08);
    check("add1_pc", int'(pc), 1);
    check("add1_zc", {int'(zero), int'(carry)}, 0);

    apply(0, 1, 1, 'hFF, 'h01);
`ifdef ALU_PC_SAT_EN
    check("add2_out", int'(out), 'hFF);
    check("add2_zero", int'(zero), 0);
`else
    check("add2_out", int'(out), 'h00);
    check("add2_zero", int'(zero), 1);
`endif
    check("add2_carry", int'(carry), 1);
    check("add2_pc", int'(pc), 2);

    apply(0, 1, 6, 'h05, 'h00);
    check("ju_wrap_pc", int'(pc), 'hFD);
    apply(0, 1, 5, 'h05, 'h00);
    check("jd_wrap_pc", int'(pc), 'h02);
    check("jump_out_hold", int'(out), m_out);

    apply(0, 1, 5, 'h0E, 'h07);
    check("jd_pc10", int'(pc), 'h10);
    apply(0, 1, 3, 'h04, 'h00);
    check("cjd_taken", int'(pc), 'h14);
    apply(0, 1, 3, 'h04, 'h01);
    check("cjd_not", int'(pc), 'h15);
    apply(0, 1, 4, 'h05, 'h00);
    check("cju_taken", int'(pc), 'h10);
    apply(0, 1, 4, 'h05, 'h80);
    check("cju_not", int'(pc), 'h11);

    apply(0, 1, 2, 'h03, 'h05);
    check("sub1_out", int'(out), 'h02);
    apply(0, 1, 2, 'h05, 'h03);
`ifdef ALU_PC_SAT_EN
    check("sub2_out", int'(out), 'h00);
`else
    check("sub2_out", int'(out), 'hFE);
`endif
    check("sub2_carry", int'(carry), 1);
    apply(0, 1, 2, 'h07, 'h07);
    check("sub3_zero", int'(zero), 1);
    apply(0, 1, 0, 'h00, 'h00);
    apply(0, 1, 0, 'h42, 'h00);
    check("pass_out", int'(out), 'h42);
    apply(0, 1, 5, 'h00, 'h00);
    apply(0, 1, 5, 'hFF, 'h00);
    apply(0, 1, 4, 'h00, 'h00);
    for (int i = 0; i < 3; i++) apply(0, 0, 1, 'h11, 'h22);

    apply(0, 1, 7, 'h00, 'h00);
    check("halt_flag", int'(halted), 1);
    apply(0, 1, 1, 'h01, 'h01);
    apply(0, 1, 5, 'h09, 'h00);
    check("halt_hold_out", int'(out), 'h42);
    apply(1, 0, 0, 0, 0);
    check("unhalt_pc", int'(pc), 0);
    check("unhalt_flag", int'(halted), 0);

    apply(0, 1, 0, 'h33, 'h00);
    apply(1, 1, 5, 'h20, 'h00);
    check("rst_wins_pc", int'(pc), 0);
    check("rst_wins_out", int'(out), 0);
    for (int i = 0; i < 5; i++) apply(0, 0, 5, 'h20, 'h00);
    check("idle_pc", int'(pc), 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
